// File: rtl/int_hazard_ctrl.sv
// int_hazard_ctrl: IF/ID + PC sequencer arbitrating load-use stalls, taken-branch flushes and a single-level interrupt save/drain/vector/restore sequence
module int_hazard_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0100,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_req,
    input  logic        int_en,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic        id_is_branch,
    input  logic        id_is_eret,
    input  logic [31:0] pc_cur,
    output logic        PCWrite,
    output logic [1:0]  pc_sel,
    output logic [31:0] epc,
    output logic        IF_IDWrite,
    output logic        IF_Flush,
    output logic        ID_EX_Flush,
    output logic        INT_detected,
    output logic        INT_restore,
    output logic        int_ack,
    output logic        int_active
);
    typedef enum logic [2:0] {
        S_RUN,
        S_SAVE,
        S_DRAIN,
        S_VECTOR,
        S_HANDLER,
        S_RESTORE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

    // The handler vector is PC-aligned and the drain count must fit the 4-bit counter.
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || HANDLER_ADDR[1:0] != 2'b00) begin : g_param_check
        $error("int_hazard_ctrl: DRAIN_CYCLES must be 1..15 and HANDLER_ADDR word aligned");
    end

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_epc;
    logic        w_accept;
    logic        w_eret;

    // An interrupt is only taken on a clean RUN cycle; an eret leaves the handler only when it is not stalled or overridden by a branch.
    assign w_accept = (r_state == S_RUN) & int_req & int_en & ~branch_taken & ~load_use & ~id_is_branch;
    assign w_eret   = (r_state == S_HANDLER) & id_is_eret & ~load_use & ~branch_taken;
    assign epc      = r_epc;

    // Sequence state, drain counter and the resume PC captured at accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_RUN;
            r_cnt   <= 4'd0;
            r_epc   <= 32'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_accept) begin
                        r_epc   <= pc_cur + 32'd4;
                        r_state <= S_SAVE;
                    end
                end
                S_SAVE: begin
                    r_cnt   <= CNT_INIT;
                    r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (r_cnt == 4'd0)
                        r_state <= S_VECTOR;
                    else
                        r_cnt <= r_cnt - 4'd1;
                end
                S_VECTOR:  r_state <= S_HANDLER;
                S_HANDLER: r_state <= w_eret ? S_RESTORE : S_HANDLER;
                S_RESTORE: r_state <= S_RUN;
                default:   r_state <= S_RUN;
            endcase
        end
    end

    // Pipeline controls decoded from the current state and this cycle's hazards.
    always_comb begin
        PCWrite      = 1'b0;
        pc_sel       = 2'd0;
        IF_IDWrite   = 1'b0;
        IF_Flush     = 1'b0;
        ID_EX_Flush  = 1'b0;
        INT_detected = 1'b0;
        INT_restore  = 1'b0;
        int_ack      = 1'b0;
        int_active   = (r_state != S_RUN);
        case (r_state)
            S_RUN, S_HANDLER: begin
                if (branch_taken) begin
                    IF_Flush    = 1'b1;
                    ID_EX_Flush = 1'b1;
                    PCWrite     = 1'b1;
                    IF_IDWrite  = 1'b1;
                end else if (load_use) begin
                    ID_EX_Flush = 1'b1;
                end else begin
                    PCWrite    = 1'b1;
                    IF_IDWrite = 1'b1;
                end
            end
            S_SAVE: begin
                INT_detected = 1'b1;
                int_ack      = 1'b1;
                ID_EX_Flush  = 1'b1;
            end
            S_DRAIN: ID_EX_Flush = 1'b1;
            S_VECTOR: begin
                PCWrite     = 1'b1;
                pc_sel      = 2'd1;
                IF_IDWrite  = 1'b1;
                IF_Flush    = 1'b1;
                ID_EX_Flush = 1'b1;
            end
            S_RESTORE: begin
                INT_restore = 1'b1;
                PCWrite     = 1'b1;
                pc_sel      = 2'd2;
                ID_EX_Flush = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_int_hazard_ctrl.sv
// tb_int_hazard_ctrl: directed stimulus with a cycle-age interrupt model checked every cycle plus literal spot checks
module tb_int_hazard_ctrl;
    localparam int D = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        int_req = 1'b0;
    logic        int_en = 1'b0;
    logic        load_use = 1'b0;
    logic        branch_taken = 1'b0;
    logic        id_is_branch = 1'b0;
    logic        id_is_eret = 1'b0;
    logic [31:0] pc_cur = 32'd0;
    logic        PCWrite;
    logic [1:0]  pc_sel;
    logic [31:0] epc;
    logic        IF_IDWrite;
    logic        IF_Flush;
    logic        ID_EX_Flush;
    logic        INT_detected;
    logic        INT_restore;
    logic        int_ack;
    logic        int_active;

    int n_chk = 0;
    int n_fail = 0;
    bit en = 1'b0;

    int_hazard_ctrl #(.HANDLER_ADDR(32'h0000_0100), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .int_req(int_req), .int_en(int_en),
        .load_use(load_use), .branch_taken(branch_taken), .id_is_branch(id_is_branch),
        .id_is_eret(id_is_eret), .pc_cur(pc_cur), .PCWrite(PCWrite), .pc_sel(pc_sel),
        .epc(epc), .IF_IDWrite(IF_IDWrite), .IF_Flush(IF_Flush), .ID_EX_Flush(ID_EX_Flush),
        .INT_detected(INT_detected), .INT_restore(INT_restore), .int_ack(int_ack),
        .int_active(int_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_age counts cycles since accept (1 = backup, 2..D+1 = drain, D+2 = vector, >= D+3 = handler).
    bit          m_in_int = 1'b0;
    bit          m_restore = 1'b0;
    int          m_age = 0;
    logic [31:0] m_epc = 32'd0;

    always @(posedge clk) begin
        if (!reset) begin
            m_in_int  = 1'b0;
            m_restore = 1'b0;
            m_age     = 0;
            m_epc     = 32'd0;
        end else if (m_restore) begin
            m_restore = 1'b0;
        end else if (!m_in_int) begin
            if (int_req && int_en && !branch_taken && !load_use && !id_is_branch) begin
                m_in_int = 1'b1;
                m_age    = 1;
                m_epc    = pc_cur + 32'd4;
            end
        end else if (m_age >= D + 3) begin
            if (id_is_eret && !load_use && !branch_taken) begin
                m_in_int  = 1'b0;
                m_restore = 1'b1;
            end
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        if (en) begin
            logic       e_pcw, e_ifw, e_iff, e_idf, e_det, e_rst, e_ack;
            logic [1:0] e_sel;
            e_pcw = 0; e_ifw = 0; e_iff = 0; e_idf = 0; e_det = 0; e_rst = 0; e_ack = 0; e_sel = 0;
            if (m_restore) begin
                e_rst = 1; e_pcw = 1; e_sel = 2; e_idf = 1;
            end else if (!m_in_int || m_age >= D + 3) begin
                if (branch_taken) begin
                    e_iff = 1; e_idf = 1; e_pcw = 1; e_ifw = 1;
                end else if (load_use) begin
                    e_idf = 1;
                end else begin
                    e_pcw = 1; e_ifw = 1;
                end
            end else if (m_age == 1) begin
                e_det = 1; e_ack = 1; e_idf = 1;
            end else if (m_age <= D + 1) begin
                e_idf = 1;
            end else begin
                e_pcw = 1; e_sel = 1; e_iff = 1; e_idf = 1; e_ifw = 1;
            end
            chk("PCWrite", 32'(PCWrite), 32'(e_pcw));
            chk("pc_sel", 32'(pc_sel), 32'(e_sel));
            chk("IF_IDWrite", 32'(IF_IDWrite), 32'(e_ifw));
            chk("IF_Flush", 32'(IF_Flush), 32'(e_iff));
            chk("ID_EX_Flush", 32'(ID_EX_Flush), 32'(e_idf));
            chk("INT_detected", 32'(INT_detected), 32'(e_det));
            chk("INT_restore", 32'(INT_restore), 32'(e_rst));
            chk("int_ack", 32'(int_ack), 32'(e_ack));
            chk("int_active", 32'(int_active), 32'(m_in_int | m_restore));
            chk("epc", epc, m_epc);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        int_req = 0; int_en = 0; load_use = 0; branch_taken = 0;
        id_is_branch = 0; id_is_eret = 0;
    endtask

    initial begin
        nxt();
        en = 1'b1;
        nxt();
        reset = 1'b1;
        // idle after reset
        @(negedge clk);
        chk("lit_idle_pcw", 32'(PCWrite), 32'd1);
        chk("lit_idle_ifw", 32'(IF_IDWrite), 32'd1);
        chk("lit_idle_iff", 32'(IF_Flush), 32'd0);
        chk("lit_idle_active", 32'(int_active), 32'd0);
        chk("lit_idle_epc", epc, 32'd0);
        nxt();
        // branch beats load_use
        load_use = 1; branch_taken = 1;
        @(negedge clk);
        chk("lit_br_iff", 32'(IF_Flush), 32'd1);
        chk("lit_br_idf", 32'(ID_EX_Flush), 32'd1);
        chk("lit_br_pcw", 32'(PCWrite), 32'd1);
        chk("lit_br_ifw", 32'(IF_IDWrite), 32'd1);
        nxt();
        branch_taken = 0;
        @(negedge clk);
        chk("lit_lu_pcw", 32'(PCWrite), 32'd0);
        chk("lit_lu_ifw", 32'(IF_IDWrite), 32'd0);
        chk("lit_lu_idf", 32'(ID_EX_Flush), 32'd1);
        nxt();
        // clean accept at pc 0x40
        clear_in();
        int_req = 1; int_en = 1; pc_cur = 32'h40;
        @(negedge clk);
        chk("lit_accept_ack", 32'(int_ack), 32'd0);
        nxt();
        int_req = 0;
        @(negedge clk);
        chk("lit_save_det", 32'(INT_detected), 32'd1);
        chk("lit_save_ack", 32'(int_ack), 32'd1);
        chk("lit_save_iff", 32'(IF_Flush), 32'd0);
        chk("lit_save_epc", epc, 32'h44);
        nxt();
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            chk("lit_drain_pcw", 32'(PCWrite), 32'd0);
            chk("lit_drain_sel", 32'(pc_sel), 32'd0);
            nxt();
        end
        @(negedge clk);
        chk("lit_vec_sel", 32'(pc_sel), 32'd1);
        chk("lit_vec_iff", 32'(IF_Flush), 32'd1);
        nxt();
        // handler: held request must not re-enter
        int_req = 1;
        @(negedge clk);
        chk("lit_hnd_active", 32'(int_active), 32'd1);
        chk("lit_hnd_sel", 32'(pc_sel), 32'd0);
        nxt();
        nxt();
        id_is_eret = 1; branch_taken = 1;
        nxt();
        branch_taken = 0; load_use = 1;
        nxt();
        load_use = 0;
        @(negedge clk);
        chk("lit_eret_ack", 32'(int_ack), 32'd0);
        nxt();
        id_is_eret = 0; int_req = 0;
        @(negedge clk);
        chk("lit_rst_restore", 32'(INT_restore), 32'd1);
        chk("lit_rst_sel", 32'(pc_sel), 32'd2);
        chk("lit_rst_pcw", 32'(PCWrite), 32'd1);
        chk("lit_rst_iff", 32'(IF_Flush), 32'd0);
        nxt();
        @(negedge clk);
        chk("lit_back_active", 32'(int_active), 32'd0);
        chk("lit_back_epc", epc, 32'h44);
        nxt();
        // accept deferred by a branch in ID for two cycles
        int_req = 1; int_en = 1; id_is_branch = 1; pc_cur = 32'h80;
        nxt();
        nxt();
        @(negedge clk);
        chk("lit_defer_active", 32'(int_active), 32'd0);
        id_is_branch = 0; pc_cur = 32'h88;
        nxt();
        int_req = 0;
        @(negedge clk);
        chk("lit_defer_ack", 32'(int_ack), 32'd1);
        chk("lit_defer_epc", epc, 32'h8C);
        nxt();
        nxt();
        // reset in DRAIN with one count left
        reset = 0;
        nxt();
        reset = 1;
        @(negedge clk);
        chk("lit_rreset_active", 32'(int_active), 32'd0);
        chk("lit_rreset_epc", epc, 32'd0);
        chk("lit_rreset_restore", 32'(INT_restore), 32'd0);
        nxt();
        // disabled interrupts are never taken
        int_req = 1; int_en = 0; pc_cur = 32'hC0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lit_dis_active", 32'(int_active), 32'd0);
            nxt();
        end
        clear_in();
        nxt();
        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/int_hazard_ctrl.md
Name: int_hazard_ctrl

Overview:
- Pipeline sequencer that owns the IF/ID register controls (IF_IDWrite, IF_Flush, INT_detected, INT_restore) and the PC write/select.
- Arbitrates load-use stalls and taken-branch flushes in normal flow.
- Runs a single-level interrupt sequence: back up IF/ID, drain older instructions, vector to the handler, and restore IF/ID plus PC on eret.
- Sits between the hazard unit / EX branch logic and the PC + IF_ID_stage.

Parameters:
- HANDLER_ADDR, 32'h0000_0100, interrupt handler entry PC.
- DRAIN_CYCLES, 3, bubble cycles after backup so EX/MEM/WB retire (legal range 1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- int_req  input  1  level interrupt request.
- int_en  input  1  global interrupt enable.
- load_use  input  1  load-use hazard detected on ID instruction.
- branch_taken  input  1  branch/jump resolved taken in EX.
- id_is_branch  input  1  ID instruction is a branch/jump.
- id_is_eret  input  1  ID instruction is eret.
- pc_cur  input  32  current fetch PC (IF).
- PCWrite  output  1  PC register enable.
- pc_sel  output  2  0 = sequential/branch path, 1 = HANDLER_ADDR, 2 = epc, 3 = unused (never driven).
- epc  output  32  saved resume PC.
- IF_IDWrite  output  1  IF/ID enable.
- IF_Flush  output  1  clear IF/ID.
- ID_EX_Flush  output  1  insert bubble into ID/EX.
- INT_detected  output  1  IF/ID backup strobe (also zeroes ID outputs).
- INT_restore  output  1  IF/ID restore-from-backup strobe.
- int_ack  output  1  one-cycle accept pulse.
- int_active  output  1  high whenever state != RUN.

Behaviour:
- FSM states: RUN, SAVE, DRAIN, VECTOR, HANDLER, RESTORE.
- Registered state: state, 4-bit drain counter, epc. All outputs are combinational decode of state and inputs.
- Reset (reset==0 at posedge): state=RUN, cnt=0, epc=0.
- Outputs with idle inputs after reset: PCWrite=1, IF_IDWrite=1, pc_sel=0, all other outputs 0.
- Hazard arbitration (RUN and HANDLER):
  - branch_taken=1: IF_Flush=1, ID_EX_Flush=1, PCWrite=1, pc_sel=0. Branch wins over load_use.
  - else load_use=1: PCWrite=0, IF_IDWrite=0, ID_EX_Flush=1.
  - else: PCWrite=1, IF_IDWrite=1.
- Interrupt accept (RUN only):
  - Condition: int_req & int_en & !branch_taken & !load_use & !id_is_branch.
  - Otherwise acceptance is deferred, re-evaluated every cycle; no request is latched.
  - On accept, the accept cycle itself applies normal arbitration. Next edge: epc <= pc_cur + 4 (the PC after the instruction entering IF/ID), state -> SAVE.
- SAVE (1 cycle): INT_detected=1, int_ack=1, PCWrite=0, IF_IDWrite=0, ID_EX_Flush=1, IF_Flush=0. IF_Flush must never coincide with INT_detected or INT_restore. Next: cnt <= DRAIN_CYCLES-1, DRAIN.
- DRAIN: PCWrite=0, IF_IDWrite=0, ID_EX_Flush=1. Stays until cnt==0, decrementing each cycle, then goes to VECTOR. Total DRAIN residency = DRAIN_CYCLES cycles.
- VECTOR (1 cycle): PCWrite=1, pc_sel=1, IF_Flush=1, ID_EX_Flush=1. Next: HANDLER.
- HANDLER: normal arbitration. int_req ignored (no nesting). On id_is_eret & !load_use & !branch_taken, next state is RESTORE. eret under a stall waits; a taken branch takes priority for that cycle.
- RESTORE (1 cycle): INT_restore=1, PCWrite=1, pc_sel=2, ID_EX_Flush=1 (kills eret), IF_IDWrite=0, IF_Flush=0. Next: RUN.
- branch_taken/load_use in SAVE, DRAIN, VECTOR and RESTORE are ignored. By construction, branch_taken cannot occur there.
- epc holds its value outside accept. It is readable throughout the handler.
- Reset asserted in any state: next edge forces RUN, cnt=0, epc=0. No restore is performed.
- int_req deasserting after accept does not abort the sequence.

Test Plan:
- Reset, then idle inputs -> PCWrite=1, IF_IDWrite=1, all flush/INT outputs 0, int_active=0, epc=0.
- load_use=1 and branch_taken=1 in the same cycle in RUN -> IF_Flush=1, ID_EX_Flush=1, PCWrite=1, IF_IDWrite=1. With load_use alone -> PCWrite=0, IF_IDWrite=0, ID_EX_Flush=1.
- int_req=1, int_en=1, pc_cur=0x40, clean cycle -> next cycle SAVE with INT_detected=1 and int_ack=1, epc=0x44. Then exactly 3 DRAIN cycles (PCWrite=0), then VECTOR with pc_sel=1, IF_Flush=1, then HANDLER.
- In HANDLER, id_is_eret=1 -> one cycle INT_restore=1, pc_sel=2, PCWrite=1, IF_Flush=0, then RUN. int_req held high in HANDLER produces no second int_ack.
- int_req=1 with id_is_branch=1 for 2 cycles, then 0 -> accept is deferred to the 3rd cycle; int_en=0 -> never accepted.
- reset=0 pulsed during DRAIN (cnt=1) -> next cycle RUN, int_active=0, epc=0, INT_restore never asserted.
